data_mem_responder: RTL



---
 rtl/data_mem_responder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side end of the CPU data-memory interface.
// Accepts one load/store at a time over valid/ready, waits a fixed LATENCY,
// then returns a one-cycle response carrying read data or the merged write word.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   is_input_valid    request present this cycle
//   addr, mem_rw      byte address; 0 = read, 1 = write
//   din, wstrb        write data and byte-lane enables
//   is_ready          responder idle and able to accept
//   is_output_valid   one-cycle response strobe
//   dout, is_error    response word; misaligned-request flag (held until next commit)
module data_mem_responder #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned DEPTH_LOG2 = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        is_input_valid,
  input  logic [31:0] addr,
  input  logic        mem_rw,
  input  logic [31:0] din,
  input  logic [3:0]  wstrb,
  output logic        is_ready,
  output logic        is_output_valid,
  output logic [31:0] dout,
  output logic        is_error
);

  localparam int unsigned DEPTH  = 32'd1 << DEPTH_LOG2;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned AW     = DEPTH_LOG2 + 2;
  localparam bit          DIRECT = (LATENCY == 32'd1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_count;
  logic [AW-1:0]    r_addr;
  logic             r_rw;
  logic [31:0]      r_din;
  logic [3:0]       r_wstrb;
  logic [31:0]      r_dout;
  logic             r_error;
  logic [31:0]      r_mem [DEPTH];
  logic [DEPTH-1:0] r_wvalid;

  logic                  w_accept;
  logic                  w_commit;
  logic [AW-1:0]         w_c_addr;
  logic                  w_c_rw;
  logic [31:0]           w_c_din;
  logic [3:0]            w_c_wstrb;
  logic [DEPTH_LOG2-1:0] w_c_idx;
  logic                  w_c_misaligned;
  logic [31:0]           w_word;
  logic [31:0]           w_merged;
  logic                  w_unused_addr;

  // Upper address bits are ignored: the array aliases.
  assign w_unused_addr = ^addr[31:AW];

  assign w_accept = (r_state == S_IDLE) && is_input_valid;
  // LATENCY=1 commits on the acceptance edge itself, using the live request.
  assign w_commit = ((r_state == S_BUSY) && (r_count == '0)) || (DIRECT && w_accept);

  assign w_c_addr       = (r_state == S_IDLE) ? addr[AW-1:0] : r_addr;
  assign w_c_rw         = (r_state == S_IDLE) ? mem_rw       : r_rw;
  assign w_c_din        = (r_state == S_IDLE) ? din          : r_din;
  assign w_c_wstrb      = (r_state == S_IDLE) ? wstrb        : r_wstrb;
  assign w_c_idx        = w_c_addr[AW-1:2];
  assign w_c_misaligned = (w_c_addr[1:0] != 2'b00);

  // A word never written since reset reads as zero; the bitmap stands in for a full array clear.
  assign w_word = r_wvalid[w_c_idx] ? r_mem[w_c_idx] : 32'h0;

  // Byte-lane merge of write data into the current word.
  always_comb begin
    w_merged = w_word;
    for (int b = 0; b < 4; b++) begin
      if (w_c_wstrb[b]) w_merged[8*b +: 8] = w_c_din[8*b +: 8];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (is_input_valid) w_next_state = DIRECT ? S_RESP : S_BUSY;
      S_BUSY:  if (r_count == '0) w_next_state = S_RESP;
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State-decoded handshake outputs.
  always_comb begin
    is_ready        = 1'b0;
    is_output_valid = 1'b0;
    case (r_state)
      S_IDLE:  is_ready = 1'b1;
      S_RESP:  is_output_valid = 1'b1;
      default: ;
    endcase
  end

  assign dout     = r_dout;
  assign is_error = r_error;

  // Request latch, latency counter, response registers and written-word bitmap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= '0;
      r_addr   <= '0;
      r_rw     <= 1'b0;
      r_din    <= '0;
      r_wstrb  <= '0;
      r_dout   <= '0;
      r_error  <= 1'b0;
      r_wvalid <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= addr[AW-1:0];
        r_rw    <= mem_rw;
        r_din   <= din;
        r_wstrb <= wstrb;
        r_count <= CNT_W'(LATENCY - 32'd1);
      end else if ((r_state == S_BUSY) && (r_count != '0)) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (w_commit) begin
        if (w_c_misaligned) begin
          r_dout  <= '0;
          r_error <= 1'b1;
        end else begin
          r_error <= 1'b0;
          if (w_c_rw) begin
            r_dout            <= w_merged;
            r_wvalid[w_c_idx] <= 1'b1;
          end else begin
            r_dout <= w_word;
          end
        end
      end
    end
  end

  // Data array; no reset on the storage itself.
  always_ff @(posedge clk) begin
    if (!reset && w_commit && !w_c_misaligned && w_c_rw) r_mem[w_c_idx] <= w_merged;
  end

endmodule
